// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: frame layout, address view and FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int unsigned ICACHE_NSETS = 8;
   localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_NSETS);
   localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      word_t                   data;
   } icache_frame_t;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef enum logic {
      IDLE,
      FETCH
   } icache_state_t;

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: frame array with a combinational read port,
// a single write port and a whole-array invalidate.
module icache_way
   import cpu_types_pkg::*;
#(
   parameter int unsigned NSETS = ICACHE_NSETS,
   localparam int unsigned IDX_W = $clog2(NSETS)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          flush,
   input  logic [IDX_W-1:0] rd_idx,
   output icache_frame_t rd_frame,
   input  logic          we,
   input  logic [IDX_W-1:0] wr_idx,
   input  icache_frame_t wr_frame
);

   icache_frame_t frames_q [NSETS];
   icache_frame_t frames_d [NSETS];

   always_comb begin
      frames_d = frames_q;
      // flush wins over a write landing in the same cycle
      if (flush) begin
         for (int i = 0; i < NSETS; i++) begin
            frames_d[i].valid = 1'b0;
         end
      end else if (we) begin
         frames_d[wr_idx] = wr_frame;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < NSETS; i++) begin
            frames_q[i] <= '0;
         end
      end else begin
         frames_q <= frames_d;
      end
   end

   assign rd_frame = frames_q[rd_idx];

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache, one-word blocks, LRU replacement,
// zero-latency hits and single-word refills from the memory controller.
module icache_2way
   import cpu_types_pkg::*;
#(
   parameter int unsigned NSETS = ICACHE_NSETS
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        flush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
);

   localparam int unsigned IDX_W = $clog2(NSETS);
   localparam int unsigned TAG_W = 30 - IDX_W;

   icache_state_t state_q, state_d;
   logic [31:0]   miss_addr_q, miss_addr_d;
   logic [NSETS-1:0] lru_q, lru_d;

   logic [IDX_W-1:0] req_idx, miss_idx, rd_idx;
   logic [TAG_W-1:0] req_tag, miss_tag;
   icache_frame_t    frame0, frame1, wr_frame;
   logic             hit0, hit1, victim, we0, we1;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^imemaddr[1:0];

   assign req_idx  = imemaddr[IDX_W+1:2];
   assign req_tag  = imemaddr[31:IDX_W+2];
   assign miss_idx = miss_addr_q[IDX_W+1:2];
   assign miss_tag = miss_addr_q[31:IDX_W+2];

   // During a refill both ways are read at the miss set to pick the victim
   assign rd_idx = (state_q == FETCH) ? miss_idx : req_idx;

   assign hit0 = (state_q == IDLE) & imemREN & frame0.valid & (frame0.tag == req_tag);
   assign hit1 = (state_q == IDLE) & imemREN & frame1.valid & (frame1.tag == req_tag);

   assign victim   = !frame0.valid ? 1'b0 : (!frame1.valid ? 1'b1 : lru_q[miss_idx]);
   assign wr_frame = '{valid: 1'b1, tag: miss_tag, data: iload};

   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      lru_d       = lru_q;
      we0         = 1'b0;
      we1         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hit0 | hit1) begin
               lru_d[req_idx] = hit0;
            end
            if (imemREN && !(hit0 | hit1) && !flush) begin
               miss_addr_d = {imemaddr[31:2], 2'b00};
               state_d     = FETCH;
            end
         end
         FETCH: begin
            if (flush) begin
               state_d = IDLE;
            end else if (!iwait) begin
               we0             = !victim;
               we1             = victim;
               lru_d[miss_idx] = !victim;
               state_d         = IDLE;
            end
         end
      endcase
      if (flush) begin
         lru_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         lru_q       <= '0;
      end else begin
         state_q     <= state_d;
         miss_addr_q <= miss_addr_d;
         lru_q       <= lru_d;
      end
   end

   assign ihit     = hit0 | hit1;
   assign imemload = hit0 ? frame0.data : (hit1 ? frame1.data : '0);
   assign iREN     = (state_q == FETCH);
   assign iaddr    = (state_q == FETCH) ? miss_addr_q : '0;

   icache_way #(.NSETS(NSETS)) u_way0 (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (flush),
      .rd_idx   (rd_idx),
      .rd_frame (frame0),
      .we       (we0),
      .wr_idx   (miss_idx),
      .wr_frame (wr_frame)
   );

   icache_way #(.NSETS(NSETS)) u_way1 (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (flush),
      .rd_idx   (rd_idx),
      .rd_frame (frame1),
      .we       (we1),
      .wr_idx   (miss_idx),
      .wr_frame (wr_frame)
   );

endmodule

// File: tb/tb_icache_2way.sv
// Bench for icache_2way: recency-list cache model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_icache_2way;

   localparam int NSETS = 8;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        flush = 1'b0;
   logic        ihit, iREN, iwait;
   logic [31:0] imemload, iaddr, iload;

   int n_cmp = 0;
   int n_err = 0;
   int mem_lat = 2;
   int wait_cnt = 2;

   icache_2way #(.NSETS(NSETS)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .flush    (flush),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ 32'h2001_0004;
   endfunction

   // Memory: each request is busy for mem_lat cycles, then data is returned
   assign iload = mem_fn(iaddr);
   assign iwait = (wait_cnt != 0);
   always @(posedge CLK) begin
      if (iREN !== 1'b1) wait_cnt <= mem_lat;
      else if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
      else wait_cnt <= mem_lat;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: per set, up to two resident word addresses ordered by recency
   logic [29:0] m_mru [NSETS];
   logic [29:0] m_lru [NSETS];
   int          m_cnt [NSETS];
   bit          m_fetch = 1'b0;
   bit          m_ok = 1'b0;
   logic [31:0] m_miss = '0;

   function automatic int set_of(input logic [31:0] a);
      return int'((a >> 2) % NSETS);
   endfunction

   function automatic bit m_has(input logic [31:0] a);
      int s = set_of(a);
      return (m_cnt[s] >= 1 && m_mru[s] == a[31:2]) || (m_cnt[s] == 2 && m_lru[s] == a[31:2]);
   endfunction

   task automatic m_clear();
      for (int s = 0; s < NSETS; s++) m_cnt[s] = 0;
   endtask

   task automatic m_touch(input logic [31:0] a);
      int s = set_of(a);
      if (m_cnt[s] == 2 && m_lru[s] == a[31:2]) begin
         m_lru[s] = m_mru[s];
         m_mru[s] = a[31:2];
      end
   endtask

   task automatic m_insert(input logic [31:0] a);
      int s = set_of(a);
      if (m_cnt[s] >= 1) m_lru[s] = m_mru[s];
      m_mru[s] = a[31:2];
      if (m_cnt[s] < 2) m_cnt[s]++;
   endtask

   always @(posedge CLK) begin
      if (!nRST) begin
         m_clear();
         m_fetch = 1'b0;
         m_ok = 1'b1;
      end else if (!m_fetch) begin
         if (imemREN && m_has(imemaddr)) m_touch(imemaddr);
         if (flush) m_clear();
         else if (imemREN && !m_has(imemaddr)) begin
            m_fetch = 1'b1;
            m_miss = {imemaddr[31:2], 2'b00};
         end
      end else begin
         if (flush) begin
            m_clear();
            m_fetch = 1'b0;
         end else if (!iwait) begin
            m_insert(m_miss);
            m_fetch = 1'b0;
         end
      end
   end

   bit          e_hit, e_ren;
   logic [31:0] e_data, e_addr;

   always @(negedge CLK) begin
      if (m_ok) begin
         if (!m_fetch) begin
            e_hit  = imemREN && m_has(imemaddr);
            e_data = e_hit ? mem_fn({imemaddr[31:2], 2'b00}) : 32'h0;
            e_ren  = 1'b0;
            e_addr = 32'h0;
         end else begin
            e_hit  = 1'b0;
            e_data = 32'h0;
            e_ren  = 1'b1;
            e_addr = m_miss;
         end
         check("cyc_ihit", 32'(ihit), 32'(e_hit));
         check("cyc_imemload", imemload, e_data);
         check("cyc_iREN", 32'(iREN), 32'(e_ren));
         check("cyc_iaddr", iaddr, e_addr);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Requests addr until ihit; checks the number of non-hit cycles before it
   task automatic access(input logic [31:0] addr, input int exp_wait, input string name);
      int  n = 0;
      bit  got = 1'b0;
      imemREN = 1'b1;
      imemaddr = addr;
      while (!got && n <= 20) begin
         @(negedge CLK);
         if (ihit === 1'b1) got = 1'b1;
         else begin
            n++;
            step();
         end
      end
      check(name, 32'(n), 32'(exp_wait));
      step();
      imemREN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  found;

      step();
      step();
      @(negedge CLK);
      check("rst_ihit", 32'(ihit), 32'h0);
      check("rst_imemload", imemload, 32'h0);
      check("rst_iREN", 32'(iREN), 32'h0);
      check("rst_iaddr", iaddr, 32'h0);
      step();
      nRST = 1'b1;

      // First miss: three fetch cycles, hit in the fourth cycle after the request
      imemREN = 1'b1;
      imemaddr = 32'h0;
      @(negedge CLK);
      check("t1_req_ihit", 32'(ihit), 32'h0);
      check("t1_req_iREN", 32'(iREN), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge CLK);
         check("t1_fetch_iREN", 32'(iREN), 32'h1);
         check("t1_fetch_iaddr", iaddr, 32'h0);
      end
      step();
      @(negedge CLK);
      check("t1_ihit", 32'(ihit), 32'h1);
      check("t1_data", imemload, 32'h2001_0004);
      step();
      imemREN = 1'b0;
      access(32'h0, 0, "t1_rehit");

      // Conflict set 1
      mem_lat = 1;
      access(32'h004, 3, "c_fill_004");
      access(32'h024, 3, "c_fill_024");
      access(32'h004, 0, "c_hit_004");
      access(32'h024, 0, "c_hit_024");
      access(32'h044, 3, "c_fill_044");
      access(32'h024, 0, "c_still_024");
      access(32'h004, 3, "c_refill_004");

      // Redirect during refill
      mem_lat = 3;
      imemREN = 1'b1;
      imemaddr = 32'h100;
      step();
      imemaddr = 32'h200;
      @(negedge CLK);
      check("r_iaddr_kept", iaddr, 32'h100);
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         step();
         @(negedge CLK);
         if (iREN === 1'b1 && iaddr === 32'h200) found = 1'b1;
         n++;
      end
      check("r_new_miss", 32'(found), 32'h1);
      found = 1'b0;
      n = 0;
      while (!found && n < 20) begin
         step();
         @(negedge CLK);
         if (ihit === 1'b1) found = 1'b1;
         n++;
      end
      check("r_hit_200", 32'(found), 32'h1);
      check("r_data_200", imemload, 32'h2001_0204);
      step();
      imemREN = 1'b0;
      access(32'h100, 0, "r_filled_100");

      // Flush with both addresses warm; the flush-cycle lookup still hits
      mem_lat = 1;
      access(32'h200, 0, "f_warm_200");
      imemREN = 1'b1;
      imemaddr = 32'h100;
      flush = 1'b1;
      @(negedge CLK);
      check("f_hit_in_flush", 32'(ihit), 32'h1);
      step();
      flush = 1'b0;
      imemREN = 1'b0;
      access(32'h100, 3, "f_miss_100");
      access(32'h200, 3, "f_miss_200");

      // Flush during refill
      mem_lat = 3;
      imemREN = 1'b1;
      imemaddr = 32'h300;
      step();
      flush = 1'b1;
      imemREN = 1'b0;
      @(negedge CLK);
      check("ff_iren_fetch", 32'(iREN), 32'h1);
      step();
      flush = 1'b0;
      @(negedge CLK);
      check("ff_iren_drop", 32'(iREN), 32'h0);
      step();
      mem_lat = 1;
      access(32'h300, 3, "ff_miss_300");

      // Idle lookups of a cached address must not touch LRU
      access(32'h008, 3, "l_fill_008");
      access(32'h028, 3, "l_fill_028");
      imemaddr = 32'h008;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         check("l_idle_ihit", 32'(ihit), 32'h0);
         check("l_idle_data", imemload, 32'h0);
         step();
      end
      access(32'h048, 3, "l_evict_008");
      access(32'h028, 0, "l_keep_028");
      access(32'h008, 3, "l_miss_008");

      // Reset arriving on the same edge the refill would complete
      mem_lat = 0;
      imemREN = 1'b1;
      imemaddr = 32'h00C;
      step();
      nRST = 1'b0;
      imemREN = 1'b0;
      @(negedge CLK);
      check("rf_iren_fetch", 32'(iREN), 32'h1);
      check("rf_iwait", 32'(iwait), 32'h0);
      step();
      nRST = 1'b1;
      @(negedge CLK);
      check("rf_iren_after", 32'(iREN), 32'h0);
      check("rf_iaddr_after", iaddr, 32'h0);
      step();
      access(32'h00C, 2, "rf_miss_00c");
      access(32'h000, 2, "rf_miss_000");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
